// File: rtl/pipeline_frame_ctrl_pkg.sv
// rtl/pipeline_frame_ctrl_pkg.sv - shared types and defaults for the frame controller
//
// Purpose : mode and state encodings, default image geometry and drain
//           timeout, plus a helper that says whether a mode runs Sobel.
// Ports   : none (package).

package pipeline_frame_ctrl_pkg;

  localparam int DEF_IMG_WIDTH     = 8;
  localparam int DEF_IMG_HEIGHT    = 8;
  localparam int DEF_DRAIN_TIMEOUT = 64;

  // Datapath select encoding; bypass is the reset value.
  typedef enum logic [1:0] {
    MODE_FULL   = 2'b00,
    MODE_SOBEL  = 2'b01,
    MODE_GRAY   = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Sobel modes lose the one-pixel border, so they need a start pulse and
  // produce a smaller output frame.
  function automatic logic mode_uses_sobel(input mode_e m);
    return (m == MODE_FULL) || (m == MODE_SOBEL);
  endfunction

endpackage

// File: rtl/pipeline_frame_ctrl.sv
// rtl/pipeline_frame_ctrl.sv - frame sequencing FSM for the image pipeline
//
// Purpose : latches a requested mode, starts a frame, forwards source pixel
//           strobes into the datapath, counts returned pixels and signals
//           frame completion or a drain timeout.
// Ports   : clk_i, nreset_i     clock, asynchronous active-low reset
//           cfg_mode_i/cfg_wr_i pending-mode write
//           frame_start_i       frame request (honoured only in IDLE)
//           src_px_rdy_i        source pixel strobe
//           pipe_px_rdy_i       output pixel strobe from the datapath
//           select_o            active mode to the datapath
//           start_sobel_o       one-cycle Sobel start pulse
//           pipe_px_rdy_o       gated source strobe (STREAM only)
//           busy_o              frame in progress
//           frame_done_o        one-cycle completion pulse
//           timeout_o           sticky drain-timeout flag

module pipeline_frame_ctrl
  import pipeline_frame_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH     = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT    = DEF_IMG_HEIGHT,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic [1:0] cfg_mode_i,
  input  logic       cfg_wr_i,
  input  logic       frame_start_i,
  input  logic       src_px_rdy_i,
  input  logic       pipe_px_rdy_i,
  output logic [1:0] select_o,
  output logic       start_sobel_o,
  output logic       pipe_px_rdy_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       timeout_o
);

  localparam int TOTAL_PX = IMG_WIDTH * IMG_HEIGHT;
  localparam int EDGE_PX  = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
  localparam int CNT_W    = $clog2(TOTAL_PX + 1);
  localparam int IDLE_W   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TOTAL_C    = CNT_W'(TOTAL_PX);
  localparam logic [CNT_W-1:0]  TOTAL_M1_C = CNT_W'(TOTAL_PX - 1);
  localparam logic [CNT_W-1:0]  EDGE_C     = CNT_W'(EDGE_PX);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] TIMEOUT_C  = IDLE_W'(DRAIN_TIMEOUT);

  state_e             state_q;
  mode_e              pending_q;
  mode_e              select_q;
  logic               start_sobel_q;
  logic               busy_q;
  logic               frame_done_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   in_cnt_q;
  logic [CNT_W-1:0]   out_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;

  mode_e              start_mode;
  logic               in_strobe;
  logic               in_last;
  logic               out_strobe;
  logic               out_reached;
  logic [CNT_W-1:0]   out_cnt_nxt;
  logic [CNT_W-1:0]   exp_cnt;
  logic [IDLE_W-1:0]  idle_cnt_nxt;

  // A write in the same cycle as the start request must win over the
  // previously pending mode.
  assign start_mode = cfg_wr_i ? mode_e'(cfg_mode_i) : pending_q;

  // The only combinational output: source strobes pass straight through
  // while streaming and are dropped everywhere else.
  assign in_strobe     = (state_q == ST_STREAM) && src_px_rdy_i;
  assign pipe_px_rdy_o = in_strobe;
  assign in_last       = in_strobe && (in_cnt_q == TOTAL_M1_C);

  assign out_strobe  = pipe_px_rdy_i && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));
  assign out_cnt_nxt = (out_strobe && (out_cnt_q != CNT_MAX)) ? out_cnt_q + CNT_ONE : out_cnt_q;
  assign exp_cnt     = mode_uses_sobel(select_q) ? EDGE_C : TOTAL_C;
  // Compared against the post-increment count so a strobe arriving in the
  // completing cycle is seen without an extra cycle of latency.
  assign out_reached = (out_cnt_nxt >= exp_cnt);

  // Idle counter saturates at the timeout value rather than wrapping.
  assign idle_cnt_nxt = pipe_px_rdy_i            ? '0 :
                        (idle_cnt_q != TIMEOUT_C) ? idle_cnt_q + IDLE_ONE : idle_cnt_q;

  assign select_o      = select_q;
  assign start_sobel_o = start_sobel_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;
  assign timeout_o     = timeout_q;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q       <= ST_IDLE;
      pending_q     <= MODE_BYPASS;
      select_q      <= MODE_BYPASS;
      start_sobel_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      idle_cnt_q    <= '0;
    end else begin
      start_sobel_q <= 1'b0;
      frame_done_q  <= 1'b0;

      if (cfg_wr_i) begin
        pending_q <= mode_e'(cfg_mode_i);
      end

      case (state_q)
        ST_IDLE: begin
          if (frame_start_i) begin
            select_q      <= start_mode;
            start_sobel_q <= mode_uses_sobel(start_mode);
            timeout_q     <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ST_START;
          end
        end

        ST_START: begin
          state_q <= ST_STREAM;
        end

        ST_STREAM: begin
          out_cnt_q <= out_cnt_nxt;
          if (in_strobe && (in_cnt_q != TOTAL_C)) begin
            in_cnt_q <= in_cnt_q + CNT_ONE;
          end
          // Output may already be complete when the last input arrives;
          // in that case there is nothing left to drain.
          if (in_last) begin
            if (out_reached) begin
              frame_done_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          out_cnt_q  <= out_cnt_nxt;
          idle_cnt_q <= idle_cnt_nxt;
          if (out_reached) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (idle_cnt_nxt == TIMEOUT_C) begin
            timeout_q    <= 1'b1;
            frame_done_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end

        ST_DONE: begin
          in_cnt_q   <= '0;
          out_cnt_q  <= '0;
          idle_cnt_q <= '0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_frame_ctrl.sv
// tb/tb_pipeline_frame_ctrl.sv - directed self-checking bench for pipeline_frame_ctrl

module tb_pipeline_frame_ctrl;

  logic       clk_i = 1'b0;
  logic       nreset_i;
  logic [1:0] cfg_mode_i;
  logic       cfg_wr_i;
  logic       frame_start_i;
  logic       src_px_rdy_i;
  logic       pipe_px_rdy_i;
  logic [1:0] select_o;
  logic       start_sobel_o;
  logic       pipe_px_rdy_o;
  logic       busy_o;
  logic       frame_done_o;
  logic       timeout_o;

  int checks   = 0;
  int failures = 0;

  pipeline_frame_ctrl #(
    .IMG_WIDTH    (8),
    .IMG_HEIGHT   (8),
    .DRAIN_TIMEOUT(64)
  ) dut (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .cfg_mode_i   (cfg_mode_i),
    .cfg_wr_i     (cfg_wr_i),
    .frame_start_i(frame_start_i),
    .src_px_rdy_i (src_px_rdy_i),
    .pipe_px_rdy_i(pipe_px_rdy_i),
    .select_o     (select_o),
    .start_sobel_o(start_sobel_o),
    .pipe_px_rdy_o(pipe_px_rdy_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Requests a frame in one cycle; returns at the negedge inside START.
  task automatic start_frame(input bit wr, input logic [1:0] mode);
    @(negedge clk_i);
    cfg_wr_i      = wr;
    cfg_mode_i    = mode;
    frame_start_i = 1'b1;
    @(negedge clk_i);
    cfg_wr_i      = 1'b0;
    frame_start_i = 1'b0;
    #1;
  endtask

  // Drives n_src source strobes and n_out returned strobes side by side,
  // then one quiet cycle; returns at that quiet negedge.
  task automatic stream(input int n_src, input int n_out,
                        output int fwd, output int done_seen, output int sobel_seen);
    int n;
    n = (n_src > n_out) ? n_src : n_out;
    fwd = 0; done_seen = 0; sobel_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      src_px_rdy_i  = (i < n_src);
      pipe_px_rdy_i = (i < n_out);
      #1;
      if (pipe_px_rdy_o) fwd++;
      if (frame_done_o)  done_seen++;
      if (start_sobel_o) sobel_seen++;
    end
    @(negedge clk_i);
    src_px_rdy_i  = 1'b0;
    pipe_px_rdy_i = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    nreset_i = 1'b0; cfg_mode_i = 2'b00; cfg_wr_i = 1'b0; frame_start_i = 1'b0;
    src_px_rdy_i = 1'b1; pipe_px_rdy_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++; if (select_o !== 2'b11) begin failures++; $display("FAIL reset_select: got %b expected 11", select_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (start_sobel_o !== 1'b0 || frame_done_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL reset_pulses: got sobel=%b done=%b timeout=%b expected 0 0 0", start_sobel_o, frame_done_o, timeout_o); end
    checks++; if (pipe_px_rdy_o !== 1'b0) begin failures++; $display("FAIL reset_pipe_rdy: got %b expected 0", pipe_px_rdy_o); end
    @(negedge clk_i);
    src_px_rdy_i = 1'b0;
    nreset_i     = 1'b1;
  endtask

  task automatic test_gray_frame;
    int fwd, dn, sb, pulses;
    start_frame(1'b1, 2'b10);
    checks++; if (start_sobel_o !== 1'b0) begin failures++; $display("FAIL gray_sobel: got %b expected 0", start_sobel_o); end
    checks++; if (select_o !== 2'b10 || busy_o !== 1'b1) begin
      failures++; $display("FAIL gray_start: got select=%b busy=%b expected 10 1", select_o, busy_o); end
    stream(64, 64, fwd, dn, sb);
    checks++; if (fwd != 64) begin failures++; $display("FAIL gray_forwarded: got %0d expected 64", fwd); end
    checks++; if (sb != 0 || dn != 0) begin failures++; $display("FAIL gray_early: got sobel=%0d done=%0d expected 0 0", sb, dn); end
    pulses = frame_done_o ? 1 : 0;
    checks++; if (frame_done_o !== 1'b1) begin failures++; $display("FAIL gray_done_latency: got %b expected 1", frame_done_o); end
    repeat (4) begin
      @(negedge clk_i); #1;
      if (frame_done_o) pulses++;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL gray_done_pulses: got %0d expected 1", pulses); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL gray_busy_fall: got %b expected 0", busy_o); end
  endtask

  task automatic test_full_frame;
    int fwd, dn, sb;
    @(negedge clk_i);
    cfg_wr_i = 1'b1; cfg_mode_i = 2'b00; frame_start_i = 1'b1;
    #1;
    checks++; if (start_sobel_o !== 1'b0) begin failures++; $display("FAIL full_sobel_pre: got %b expected 0", start_sobel_o); end
    @(negedge clk_i);
    cfg_wr_i = 1'b0; frame_start_i = 1'b0;
    #1;
    checks++; if (start_sobel_o !== 1'b1) begin failures++; $display("FAIL full_sobel_pulse: got %b expected 1", start_sobel_o); end
    checks++; if (select_o !== 2'b00) begin failures++; $display("FAIL full_select: got %b expected 00", select_o); end
    stream(64, 36, fwd, dn, sb);
    checks++; if (sb != 0) begin failures++; $display("FAIL full_sobel_width: got %0d extra cycles expected 0", sb); end
    checks++; if (fwd != 64 || dn != 0) begin failures++; $display("FAIL full_stream: got fwd=%0d done=%0d expected 64 0", fwd, dn); end
    checks++; if (frame_done_o !== 1'b1 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL full_done: got done=%b timeout=%b expected 1 0", frame_done_o, timeout_o); end
  endtask

  task automatic test_mode_change;
    int fwd, dn, sb;
    start_frame(1'b1, 2'b10);
    stream(10, 10, fwd, dn, sb);
    // Mode write and a stray start request mid-frame: neither may disturb it.
    @(negedge clk_i);
    cfg_wr_i = 1'b1; cfg_mode_i = 2'b01; frame_start_i = 1'b1;
    @(negedge clk_i);
    cfg_wr_i = 1'b0; frame_start_i = 1'b0;
    #1;
    checks++; if (select_o !== 2'b10) begin failures++; $display("FAIL chg_select_mid: got %b expected 10", select_o); end
    stream(54, 54, fwd, dn, sb);
    checks++; if (fwd != 54 || frame_done_o !== 1'b1) begin
      failures++; $display("FAIL chg_first_frame: got fwd=%0d done=%b expected 54 1", fwd, frame_done_o); end
    checks++; if (select_o !== 2'b10) begin failures++; $display("FAIL chg_select_end: got %b expected 10", select_o); end
    start_frame(1'b0, 2'b00);
    checks++; if (select_o !== 2'b01 || start_sobel_o !== 1'b1) begin
      failures++; $display("FAIL chg_next_frame: got select=%b sobel=%b expected 01 1", select_o, start_sobel_o); end
    stream(64, 0, fwd, dn, sb);
    checks++; if (fwd != 64 || dn != 0 || busy_o !== 1'b1) begin
      failures++; $display("FAIL chg_drain_entry: got fwd=%0d done=%0d busy=%b expected 64 0 1", fwd, dn, busy_o); end
    stream(0, 36, fwd, dn, sb);
    checks++; if (dn != 0 || frame_done_o !== 1'b1 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL chg_drain_done: got early=%0d done=%b timeout=%b expected 0 1 0", dn, frame_done_o, timeout_o); end
  endtask

  task automatic test_overrun;
    int fwd, dn, sb;
    start_frame(1'b1, 2'b11);
    stream(70, 0, fwd, dn, sb);
    checks++; if (fwd != 64) begin failures++; $display("FAIL overrun_forwarded: got %0d expected 64", fwd); end
    stream(0, 64, fwd, dn, sb);
    checks++; if (dn != 0 || frame_done_o !== 1'b1) begin
      failures++; $display("FAIL overrun_done: got early=%0d done=%b expected 0 1", dn, frame_done_o); end
  endtask

  task automatic test_timeout;
    int fwd, dn, sb, k;
    start_frame(1'b1, 2'b00);
    stream(64, 20, fwd, dn, sb);
    // Now in DRAIN with an idle count of 0; 64 silent cycles, then DONE.
    k = 1;
    while (!frame_done_o && k <= 200) begin
      @(negedge clk_i); #1;
      k++;
    end
    checks++; if (k != 65) begin failures++; $display("FAIL timeout_latency: got %0d cycles expected 65", k); end
    checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL timeout_flag: got %b expected 1", timeout_o); end
    repeat (2) @(negedge clk_i);
    #1;
    checks++; if (timeout_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++; $display("FAIL timeout_sticky: got timeout=%b busy=%b expected 1 0", timeout_o, busy_o); end
    start_frame(1'b0, 2'b00);
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b expected 0", timeout_o); end
    stream(64, 36, fwd, dn, sb);
    checks++; if (frame_done_o !== 1'b1 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL timeout_next_frame: got done=%b timeout=%b expected 1 0", frame_done_o, timeout_o); end
  endtask

  task automatic test_reset_mid;
    int fwd, dn, sb;
    start_frame(1'b1, 2'b10);
    stream(30, 0, fwd, dn, sb);
    @(negedge clk_i);
    src_px_rdy_i = 1'b1;
    nreset_i     = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || select_o !== 2'b11) begin
      failures++; $display("FAIL rstmid_state: got busy=%b select=%b expected 0 11", busy_o, select_o); end
    checks++; if (pipe_px_rdy_o !== 1'b0) begin failures++; $display("FAIL rstmid_pipe_rdy: got %b expected 0", pipe_px_rdy_o); end
    @(negedge clk_i);
    nreset_i     = 1'b1;
    src_px_rdy_i = 1'b0;
    start_frame(1'b0, 2'b00);
    checks++; if (select_o !== 2'b11 || start_sobel_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_pending: got select=%b sobel=%b expected 11 0", select_o, start_sobel_o); end
    stream(64, 64, fwd, dn, sb);
    checks++; if (fwd != 64 || dn != 0) begin failures++; $display("FAIL rstmid_count: got fwd=%0d done=%0d expected 64 0", fwd, dn); end
    checks++; if (frame_done_o !== 1'b1) begin failures++; $display("FAIL rstmid_done: got %b expected 1", frame_done_o); end
  endtask

  initial begin
    test_reset();
    test_gray_frame();
    test_full_frame();
    test_mode_change();
    test_overrun();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
